// File: rtl/clk_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_meter_pkg
// Shared types and default constants for the clock period meter.
//   state_e          : measurement FSM state (IDLE / HIGH / LOW), 2 bits
//   DEF_CNT_W        : default width of the high/low phase counters
//   DEF_SYNC_STAGES  : default synchronizer depth (minimum 2)
//   DEF_EXP_HIGH     : default expected high count for the self-check option
//   DEF_EXP_PERIOD   : default expected period count for the self-check option
// -----------------------------------------------------------------------------
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_EXP_HIGH    = 2;
  localparam int DEF_EXP_PERIOD  = 6;

endpackage

// File: rtl/clk_period_meter_if.sv
// -----------------------------------------------------------------------------
// clk_period_meter_if
// Result bus of the clock period meter.
//   high_cnt   : clk_in cycles the measured clock was high (last full period)
//   low_cnt    : clk_in cycles the measured clock was low  (last full period)
//   period_cnt : high_cnt + low_cnt, one bit wider
//   meas_valid : one-cycle pulse when new results are loaded
//   ovf        : a counter saturated during the reported period
//   match, mismatch_sticky : present only with CLK_PERIOD_METER_CHECK_EN
// Modports: master (the meter drives), slave (display / checker consumes).
// -----------------------------------------------------------------------------
interface clk_period_meter_if
  import clk_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period_cnt;
  logic             meas_valid;
  logic             ovf;
`ifdef CLK_PERIOD_METER_CHECK_EN
  logic             match;
  logic             mismatch_sticky;
`endif

  modport master (
    output high_cnt, low_cnt, period_cnt, meas_valid, ovf
`ifdef CLK_PERIOD_METER_CHECK_EN
    , output match, mismatch_sticky
`endif
  );

  modport slave (
    input high_cnt, low_cnt, period_cnt, meas_valid, ovf
`ifdef CLK_PERIOD_METER_CHECK_EN
    , input match, mismatch_sticky
`endif
  );

endinterface

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk domain through SYNC_STAGES flops,
// then delays it one more cycle to detect edges.  Also used for buttons.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   level      : synchronized level
//   rise, fall : single-cycle pulses on synchronized edges
// -----------------------------------------------------------------------------
module sync_edge_det
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // NOTE: the synchronizer is a handful of flops, not a memory, so it is
  // reset; a clean 0 after reset keeps a spurious edge out of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give every stage the pre-edge value
      // of its neighbour; blocking ones would collapse the chain to one flop.
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
// Measures the high time, low time and period (in clk_in cycles) of a divided
// clock sampled as asynchronous data.  Results are reported once per complete
// period; a partial first period is never reported.
//   clk_in   : system clock, all logic on posedge
//   rst_n    : asynchronous active-low reset
//   en       : measurement enable, low forces IDLE (results are kept)
//   meas_clk : clock under measurement, treated as asynchronous data
//   res      : result bus (clk_period_meter_if.master)
// Optional: define CLK_PERIOD_METER_CHECK_EN to add match / mismatch_sticky,
// comparing each result against EXP_HIGH and EXP_PERIOD.
// -----------------------------------------------------------------------------
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int EXP_HIGH    = DEF_EXP_HIGH,
  parameter int EXP_PERIOD  = DEF_EXP_PERIOD
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               en,
  input  logic               meas_clk,
  clk_period_meter_if.master res
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Catch unusable parameter sets at elaboration time.
  if (SYNC_STAGES < 2 || EXP_HIGH < 0 || EXP_HIGH >= (1 << CNT_W) ||
      EXP_PERIOD < 0 || EXP_PERIOD >= (1 << (CNT_W + 1))) begin : g_bad_params
    $error("clk_period_meter: SYNC_STAGES < 2 or expected counts out of range");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detector.  Only the edges drive the FSM.
  // ---------------------------------------------------------------------------
  logic unused_level;
  logic s_rise, s_fall;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (meas_clk),
    .level (unused_level),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  // ---------------------------------------------------------------------------
  // Measurement FSM and phase counters
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] lc_q, lc_d;
  logic             sat_q, sat_d;   // a counter tried to pass all-ones
  logic             load;           // closing rise: capture results

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    hc_d    = hc_q;
    lc_d    = lc_q;
    sat_d   = sat_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_rise) begin
          state_d = HIGH;
          hc_d    = CNT_W'(1);      // the rise cycle itself is high time
          lc_d    = '0;
          sat_d   = 1'b0;
        end
      end
      HIGH: begin
        if (s_fall) begin
          state_d = LOW;
          lc_d    = CNT_W'(1);
        end else if (hc_q == CNT_MAX) begin
          sat_d   = 1'b1;
        end else begin
          hc_d    = hc_q + CNT_W'(1);
        end
      end
      LOW: begin
        if (s_rise) begin
          load    = 1'b1;
          state_d = HIGH;
          hc_d    = CNT_W'(1);
          lc_d    = '0;
          sat_d   = 1'b0;
        end else if (lc_q == CNT_MAX) begin
          sat_d   = 1'b1;
        end else begin
          lc_d    = lc_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything, including a closing rise in this cycle.
    if (!en) begin
      state_d = IDLE;
      hc_d    = '0;
      lc_d    = '0;
      sat_d   = 1'b0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hc_q    <= '0;
      lc_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      lc_q    <= lc_d;
      sat_q   <= sat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: updated on load, held otherwise
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = load;
    if (load) begin
      high_d   = hc_q;
      low_d    = lc_q;
      period_d = {1'b0, hc_q} + {1'b0, lc_q};
      ovf_d    = sat_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign res.high_cnt   = high_q;
  assign res.low_cnt    = low_q;
  assign res.period_cnt = period_q;
  assign res.meas_valid = valid_q;
  assign res.ovf        = ovf_q;

`ifdef CLK_PERIOD_METER_CHECK_EN
  // ---------------------------------------------------------------------------
  // Self-check against the expected divider shape
  // ---------------------------------------------------------------------------
  logic match_q, match_d;
  logic sticky_q, sticky_d;

  always_comb begin
    match_d  = match_q;
    sticky_d = sticky_q;
    if (load) begin
      match_d  = (hc_q == CNT_W'(EXP_HIGH)) &&
                 (period_d == (CNT_W + 1)'(EXP_PERIOD)) && !sat_q;
      sticky_d = sticky_q | ~match_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      match_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      match_q  <= match_d;
      sticky_q <= sticky_d;
    end
  end

  assign res.match           = match_q;
  assign res.mismatch_sticky = sticky_q;
`endif

endmodule
